// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared state encoding and constants for the multi-cycle divider
package div_ctrl_pkg;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [31:0] DIV_DBZ_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring shift-subtract step on {rem, quo}
module div_iter_step
    import div_ctrl_pkg::*;
#(
    parameter int W = DIV_ITER
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic [W-1:0] quo_o
);

    logic [W+1:0] rem_sh;
    logic [W+1:0] diff;

    assign rem_sh = {rem_i, quo_i[W-1]};
    assign diff   = rem_sh - {2'b00, divisor_i};

    // A clear top bit of diff means the trial subtraction did not go negative.
    always_comb begin
        rem_o = rem_sh[W:0];
        quo_o = {quo_i[W-2:0], 1'b0};
        if (!diff[W+1]) begin
            rem_o    = diff[W:0];
            quo_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - 32-iteration restoring divider sequencer with pipeline stall and flush
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic              mod_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              stallreq_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] result_o
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W:0]      rem_q, rem_d;
    logic [DATA_W-1:0]    quo_q, quo_d;
    logic [DATA_W-1:0]    dsr_q, dsr_d;
    logic [DATA_W-1:0]    dnd_q, dnd_d;
    logic                 mod_q, mod_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [DATA_W-1:0]    result_q, result_d;

    logic [DATA_W:0]      step_rem;
    logic [DATA_W-1:0]    step_quo;
    logic [DATA_W-1:0]    dnd_mag;
    logic [DATA_W-1:0]    dsr_mag;

    assign dnd_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    assign dsr_mag = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

    div_iter_step #(.W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsr_d      = dsr_q;
        dnd_d      = dnd_q;
        mod_d      = mod_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        result_d   = result_q;
        stallreq_o = 1'b0;
        ready_o    = 1'b0;

        case (state_q)
            DivFree: begin
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    dnd_d      = dividend_i;
                    mod_d      = mod_i;
                    quo_d      = dnd_mag;
                    dsr_d      = dsr_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    negq_d     = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                    negr_d     = signed_i & dividend_i[DATA_W-1];
                    state_d    = (divisor_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = mod_q ? dnd_q : DATA_W'(DIV_DBZ_QUO);
                end
            end
            DivOn: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    // Sign fix is applied to the final step's output so the result lands on entry to END.
                    if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                        state_d  = DivEnd;
                        result_d = mod_q ? (negr_q ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0])
                                         : (negq_q ? -step_quo : step_quo);
                    end
                end
            end
            DivEnd: begin
                ready_o = !annul_i;
                state_d = DivFree;
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            dnd_q    <= '0;
            mod_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            dnd_q    <= dnd_d;
            mod_q    <= mod_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl against a latency/arithmetic model
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        mod_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        stallreq_o;
    logic        ready_o;
    logic [31:0] result_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .mod_i      (mod_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .stallreq_o (stallreq_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_div(input logic s, input logic m,
                                              input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
        if (!s) return m ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return m ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Model: an accepted request ends after a fixed latency unless flushed or reset.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_lat  = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_final = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_res  = '0;
        end else if (m_busy) begin
            if (annul_i || m_age == m_lat) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
                if (m_age == m_lat) m_res = m_final;
            end
        end else if (start_i && !annul_i) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_lat   = (divisor_i == 32'd0) ? 2 : 33;
            m_final = model_div(signed_i, mod_i, dividend_i, divisor_i);
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("stallreq", {31'd0, stallreq_o},
                  {31'd0, (!m_busy && start_i && !annul_i) || (m_busy && m_age < m_lat)});
            check("ready", {31'd0, ready_o}, {31'd0, m_busy && m_age == m_lat && !annul_i});
            check("result", result_o, m_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic s, input logic m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit scramble);
        int  lat;
        int  stalls;
        bit  seen;
        lat    = -1;
        stalls = 0;
        seen   = 1'b0;
        signed_i   = s;
        mod_i      = m;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (ready_o) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
            tick();
            if (scramble && c == 0) begin
                dividend_i = 32'h5A5A_1234;
                divisor_i  = 32'h0000_0003;
            end
        end
        check({name, " ready_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " stall_cycles"}, stalls, exp_lat);
            check({name, " value"}, result_o, exp_res);
        end
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", {31'd0, ready_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset stall", {31'd0, stallreq_o}, 32'd0);
        chk_en = 1'b1;
        tick();

        do_op("u100/7 q",   1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        33, 1'b0);
        do_op("u100/7 r",   1'b0, 1'b1, 32'd100,       32'd7,         32'd2,         33, 1'b0);
        do_op("s-7/2 q",    1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
        do_op("s-7/2 r",    1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        do_op("s7/-2 q",    1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b1);
        do_op("s7/-2 r",    1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1'b0);
        do_op("u dbz q",    1'b0, 1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 2,  1'b0);
        do_op("u dbz r",    1'b0, 1'b1, 32'h1234,      32'd0,         32'h1234,      2,  1'b0);
        do_op("s dbz q",    1'b1, 1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 2,  1'b0);
        do_op("s dbz r",    1'b1, 1'b1, 32'h1234,      32'd0,         32'h1234,      2,  1'b0);
        do_op("s dbz neg r",1'b1, 1'b1, 32'hFFFF_0000, 32'd0,         32'hFFFF_0000, 2,  1'b0);
        do_op("s ovf q",    1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
        do_op("s ovf r",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0);
        do_op("u max/1 q",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1'b0);

        signed_i   = 1'b0;
        mod_i      = 1'b0;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        @(negedge clk);
        check("annul result held", result_o, 32'hFFFF_FFFF);
        check("annul idle stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        do_op("u50/5 after annul", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 33, 1'b0);

        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        repeat (20) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset mid-on result", result_o, 32'd0);
        check("reset mid-on ready", {31'd0, ready_o}, 32'd0);
        repeat (40) tick();
        do_op("u1000/10 q", 1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 33, 1'b0);
        do_op("u1000/3 r",  1'b0, 1'b1, 32'd1000, 32'd3,  32'd1,   33, 1'b0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
